// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and counter sizing.
// The PARITY state is only ever entered when PISO_SERIALIZER_PARITY_EN is defined.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable bit-position up-counter: clear has priority over enable,
// o_tc flags the last position of a data word.
module piso_bit_cnt #(
  parameter int MAX = 7,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == W'(MAX));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready input and gapless back-to-back framing.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              shift_en,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

  localparam int CW      = cnt_width(DATA_W);
  localparam int OUT_IDX = LSB_FIRST ? 0 : DATA_W - 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     w_cnt;
  logic              w_tc;
  logic              w_accept;
  logic              w_load;
  logic              w_shift;
  logic              w_clr_data;
  logic              w_frame_end;
  logic              w_in_ready;
  logic              w_bit;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic              r_parity;
`endif

`ifdef PISO_SERIALIZER_PARITY_EN
  assign w_frame_end = (r_state == PARITY);
`else
  assign w_frame_end = (r_state == SHIFT) && w_tc;
`endif

  assign w_in_ready = (r_state == IDLE) || (w_frame_end && shift_en);
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_clr_data   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (!w_tc) begin
            w_shift = 1'b1;
          end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
            w_state_next = PARITY;
`else
            if (w_accept) begin
              w_load = 1'b1;
            end else begin
              w_clr_data   = 1'b1;
              w_state_next = IDLE;
            end
`endif
          end
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (shift_en) begin
          if (w_accept) begin
            w_load       = 1'b1;
            w_state_next = SHIFT;
          end else begin
            w_clr_data   = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Shifting toward OUT_IDX keeps the presented bit at a fixed register position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
    end else if (w_load) begin
      r_shift <= in_data;
    end else if (w_clr_data) begin
      r_shift <= '0;
    end else if (w_shift) begin
      r_shift <= LSB_FIRST ? {1'b0, r_shift[DATA_W-1:1]} : {r_shift[DATA_W-2:0], 1'b0};
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^in_data;
    end else if (w_clr_data) begin
      r_parity <= 1'b0;
    end
  end
`endif

  piso_bit_cnt #(
    .MAX (DATA_W - 1),
    .W   (CW)
  ) u_bit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_load || w_clr_data),
    .i_en    (w_shift),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

`ifdef PISO_SERIALIZER_PARITY_EN
  assign w_bit = (r_state == PARITY) ? r_parity : r_shift[OUT_IDX];
`else
  assign w_bit = r_shift[OUT_IDX];
`endif

  assign in_ready     = w_in_ready;
  assign serial_out   = (r_state != IDLE) && w_bit;
  assign serial_valid = (r_state != IDLE);
  assign busy         = (r_state != IDLE);
  assign frame_start  = (r_state == SHIFT) && (w_cnt == '0);
  assign frame_end    = w_frame_end;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share one input stream
// and are checked every cycle against a frame-level model.
module tb_piso_serializer;

  localparam int DW = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          shift_en = 1'b1;

  logic m_ready, m_sout, m_sv, m_fs, m_fe, m_busy;
  logic l_ready, l_sout, l_sv, l_fs, l_fe, l_busy;

  always #5 clk = ~clk;

  piso_serializer #(.DATA_W(DW), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(m_ready), .shift_en(shift_en), .serial_out(m_sout),
    .serial_valid(m_sv), .frame_start(m_fs), .frame_end(m_fe), .busy(m_busy)
  );

  piso_serializer #(.DATA_W(DW), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(l_ready), .shift_en(shift_en), .serial_out(l_sout),
    .serial_valid(l_sv), .frame_start(l_fs), .frame_end(l_fe), .busy(l_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit k of a frame: data bits in the chosen order, then the parity bit if present.
  function automatic logic frame_bit(input logic [DW-1:0] w, input int k, input bit lsb);
    logic [2:0] i;
    if (k >= DW) return ^w;
    i = lsb ? 3'(k) : 3'(DW - 1 - k);
    return w[i];
  endfunction

  // Whole frame as it would be captured first-bit-first into a shift register.
  function automatic logic [8:0] frame_word(input logic [DW-1:0] w, input bit lsb);
    logic [8:0] r;
    r = '0;
    for (int k = 0; k < FL; k++) r = {r[7:0], frame_bit(w, k, lsb)};
    return r;
  endfunction

  // shift_en generator: 0 = always on, 1 = one cycle in four, 2 = random.
  int se_mode = 0;
  int cyc = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (se_mode)
        0:       shift_en = 1'b1;
        1:       shift_en = (cyc % 4 == 0);
        default: shift_en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic          md_act  = 1'b0;
  int            md_k    = 0;
  logic [DW-1:0] md_word = '0;
  int sv_cnt = 0, rb_cnt = 0, fs_cnt = 0, fe_cnt = 0;
  logic [8:0] cap_m = '0, cap_l = '0;

  initial begin
    logic e_fe, e_ready, acc;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk1("rst.msb.in_ready", m_ready, 1'b1);
        chk1("rst.lsb.in_ready", l_ready, 1'b1);
        chk1("rst.msb.serial_valid", m_sv, 1'b0);
        chk1("rst.lsb.serial_valid", l_sv, 1'b0);
        chk1("rst.msb.serial_out", m_sout, 1'b0);
        chk1("rst.lsb.serial_out", l_sout, 1'b0);
        chk1("rst.msb.busy", m_busy, 1'b0);
        chk1("rst.msb.frame_flags", m_fs | m_fe, 1'b0);
        md_act = 1'b0;
        md_k   = 0;
      end else begin
        e_fe    = md_act && (md_k == FL - 1);
        e_ready = !md_act || (e_fe && shift_en);
        chk1("msb.in_ready", m_ready, e_ready);
        chk1("lsb.in_ready", l_ready, e_ready);
        chk1("msb.serial_valid", m_sv, md_act);
        chk1("lsb.serial_valid", l_sv, md_act);
        chk1("msb.busy", m_busy, md_act);
        chk1("lsb.busy", l_busy, md_act);
        chk1("msb.frame_start", m_fs, md_act && (md_k == 0));
        chk1("lsb.frame_start", l_fs, md_act && (md_k == 0));
        chk1("msb.frame_end", m_fe, e_fe);
        chk1("lsb.frame_end", l_fe, e_fe);
        chk1("msb.serial_out", m_sout, md_act ? frame_bit(md_word, md_k, 1'b0) : 1'b0);
        chk1("lsb.serial_out", l_sout, md_act ? frame_bit(md_word, md_k, 1'b1) : 1'b0);

        sv_cnt += int'(m_sv);
        rb_cnt += int'(m_ready && m_busy);
        fs_cnt += int'(m_fs);
        fe_cnt += int'(m_fe);
        if (m_sv && shift_en) cap_m = m_fs ? {8'b0, m_sout} : {cap_m[7:0], m_sout};
        if (l_sv && shift_en) cap_l = l_fs ? {8'b0, l_sout} : {cap_l[7:0], l_sout};

        acc = in_valid && e_ready;
        if (md_act && shift_en) begin
          if (md_k == FL - 1) begin
            if (acc) begin
              md_word = in_data;
              md_k    = 0;
            end else begin
              md_act = 1'b0;
            end
          end else begin
            md_k++;
          end
        end else if (!md_act && acc) begin
          md_act  = 1'b1;
          md_word = in_data;
          md_k    = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [DW-1:0] w, input bit keep_valid, input bit junk);
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (m_ready) break;
      if (t > 200) begin
        chkn("send_timeout", 0, 1);
        break;
      end
      step();
      if (junk) in_data = 8'($urandom);
    end
    step();
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (!m_busy) break;
      if (t > 300) begin
        chkn("idle_timeout", 0, 1);
        break;
      end
    end
    step();
  endtask

  initial begin
    int s_sv, s_rb, s_fs, s_fe;
    #1 reset_n = 1'b0;
    #2;
    chk1("reset.in_ready", m_ready, 1'b1);
    chk1("reset.serial_valid", m_sv, 1'b0);
    chk1("reset.busy", m_busy, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // MSB-first 8'hA5 with shift_en always on
    s_sv = sv_cnt; s_fs = fs_cnt; s_fe = fe_cnt;
    send(8'hA5, 1'b0, 1'b0);
    wait_idle();
`ifdef PISO_SERIALIZER_PARITY_EN
    chkn("t1.msb_frame", int'(cap_m), 'h14A);
`else
    chkn("t1.msb_frame", int'(cap_m), 'h0A5);
`endif
    chkn("t1.valid_cycles", sv_cnt - s_sv, FL);
    chkn("t1.frame_start_cycles", fs_cnt - s_fs, 1);
    chkn("t1.frame_end_cycles", fe_cnt - s_fe, 1);

    // LSB-first palindrome and single-bit word
`ifdef PISO_SERIALIZER_PARITY_EN
    chkn("t2.lsb_a5_frame", int'(cap_l), 'h14A);
    send(8'h01, 1'b0, 1'b0);
    wait_idle();
    chkn("t2.lsb_01_frame", int'(cap_l), 'h101);
    chkn("t2.msb_01_frame", int'(cap_m), 'h003);
`else
    chkn("t2.lsb_a5_frame", int'(cap_l), 'h0A5);
    send(8'h01, 1'b0, 1'b0);
    wait_idle();
    chkn("t2.lsb_01_frame", int'(cap_l), 'h080);
    chkn("t2.msb_01_frame", int'(cap_m), 'h001);
`endif

    // Back-to-back 8'hFF then 8'h00
    s_sv = sv_cnt; s_rb = rb_cnt;
    send(8'hFF, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    wait_idle();
    chkn("t3.valid_cycles", sv_cnt - s_sv, 2 * FL);
    chkn("t3.ready_pulses_busy", rb_cnt - s_rb, 2);
    chkn("t3.last_frame", int'(cap_m), int'(frame_word(8'h00, 1'b0)));

    // One shift_en tick every 4 cycles, accept aligned to a tick
    se_mode = 1;
    step();
    for (int t = 0; t < 8 && !shift_en; t++) step();
    s_sv = sv_cnt;
    send(8'hC3, 1'b0, 1'b0);
    wait_idle();
    chkn("t4.valid_cycles", sv_cnt - s_sv, 4 * FL);
    chkn("t4.msb_frame", int'(cap_m), int'(frame_word(8'hC3, 1'b0)));
    chkn("t4.lsb_frame", int'(cap_l), int'(frame_word(8'hC3, 1'b1)));

    // Asynchronous reset while bit 3 of 8'hF0 is presented
    se_mode = 0;
    step();
    send(8'hF0, 1'b0, 1'b0);
    repeat (3) step();
    chk1("t5.pre_valid", m_sv, 1'b1);
    chk1("t5.pre_msb_bit3", m_sout, 1'b1);
    chk1("t5.pre_lsb_bit3", l_sout, 1'b0);
    reset_n = 1'b0;
    #1;
    chk1("t5.async_serial_valid", m_sv, 1'b0);
    chk1("t5.async_serial_out", m_sout, 1'b0);
    chk1("t5.async_busy", l_busy, 1'b0);
    chk1("t5.async_in_ready", m_ready, 1'b1);
    step();
    step();
    reset_n = 1'b1;
    step();
    send(8'h0F, 1'b0, 1'b0);
    wait_idle();
    chkn("t5.msb_0f_frame", int'(cap_m), int'(frame_word(8'h0F, 1'b0)));
    chkn("t5.lsb_0f_frame", int'(cap_l), int'(frame_word(8'h0F, 1'b1)));

`ifdef PISO_SERIALIZER_PARITY_EN
    send(8'h07, 1'b0, 1'b0);
    wait_idle();
    chkn("t6.msb_07_parity_frame", int'(cap_m), 'h00F);
    chkn("t6.lsb_07_parity_frame", int'(cap_l), 'h1C1);
    send(8'h03, 1'b0, 1'b0);
    wait_idle();
    chkn("t6.msb_03_parity_frame", int'(cap_m), 'h006);
    chkn("t6.lsb_03_parity_frame", int'(cap_l), 'h180);
`endif

    // Random words, gaps, data churn while stalled, random shift_en
    for (int n = 0; n < 60; n++) begin
      se_mode = (n % 3 == 0) ? 0 : 2;
      repeat ($urandom_range(0, 3)) step();
      send(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    in_valid = 1'b0;
    wait_idle();
    chk1("rand.final_idle_ready", m_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
